// File: rtl/des_stream_if.sv
// des_stream_if: byte-stream wrapper around a combinational DES core.
// Collects an optional 8-byte key and an 8-byte text block, presents them to
// the core, captures the core result after one settling cycle and streams it
// back out as 8 bytes, MSB first.
// Optional feature macro: DES_KEY_PARITY_CHECK_EN (sticky key parity flag).
module des_stream_if (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_is_key,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [63:0] des_plain_text,
    output logic [63:0] des_cipher_key,
    input  logic [63:0] des_cipher_text,
    output logic        key_loaded,
    output logic        key_parity_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_TEXT,
        CAPTURE,
        SEND
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [63:0] key_reg, text_reg, shift_reg;
    logic        loaded_reg;
    logic        wr_key, wr_text, do_capture, do_shift, set_loaded;
    logic [5:0]  byte_lsb;

    // Byte n lands at bit offset 8*(7-n); for a 3-bit count 7-n is ~n.
    assign byte_lsb       = {~cnt, 3'b000};
    assign m_data         = shift_reg[63:56];
    assign des_plain_text = text_reg;
    assign des_cipher_key = key_reg;
    assign key_loaded     = loaded_reg;

    // State and byte counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, handshake outputs and datapath enables.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        wr_key     = 1'b0;
        wr_text    = 1'b0;
        do_capture = 1'b0;
        do_shift   = 1'b0;
        set_loaded = 1'b0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    // s_is_key only matters on the first byte of a block
                    if (s_is_key) begin
                        wr_key    = 1'b1;
                        state_nxt = LOAD_KEY;
                    end else begin
                        wr_text   = 1'b1;
                        state_nxt = LOAD_TEXT;
                    end
                    cnt_nxt = 3'd1;
                end
            end
            LOAD_KEY: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wr_key = 1'b1;
                    if (cnt == 3'd7) begin
                        set_loaded = 1'b1;
                        state_nxt  = LOAD_TEXT;
                        cnt_nxt    = 3'd0;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
            end
            LOAD_TEXT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wr_text = 1'b1;
                    if (cnt == 3'd7) begin
                        state_nxt = CAPTURE;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
            end
            CAPTURE: begin
                // core has had a full cycle to settle on the new text
                do_capture = 1'b1;
                state_nxt  = SEND;
                cnt_nxt    = 3'd0;
            end
            SEND: begin
                m_valid = 1'b1;
                m_last  = (cnt == 3'd7);
                if (m_ready) begin
                    do_shift = 1'b1;
                    if (cnt == 3'd7) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Key/text assembly, result capture and output shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg    <= 64'd0;
            text_reg   <= 64'd0;
            shift_reg  <= 64'd0;
            loaded_reg <= 1'b0;
        end else begin
            if (wr_key)
                key_reg[byte_lsb +: 8] <= s_data;
            if (wr_text)
                text_reg[byte_lsb +: 8] <= s_data;
            if (do_capture)
                shift_reg <= des_cipher_text;
            else if (do_shift)
                shift_reg <= {shift_reg[55:0], 8'h00};
            if (set_loaded)
                loaded_reg <= 1'b1;
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    // DES key bytes carry odd parity in their LSB.
    function automatic logic odd_parity(input logic [7:0] b);
        return ^b;
    endfunction

    logic parity_err_reg;
    assign key_parity_err = parity_err_reg;

    // Sticky parity flag; the first byte of a key load restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_reg <= 1'b0;
        end else if (wr_key) begin
            if (state == IDLE)
                parity_err_reg <= ~odd_parity(s_data);
            else if (!odd_parity(s_data))
                parity_err_reg <= 1'b1;
        end
    end
`else
    assign key_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_stream_if.sv
// Self-checking bench for des_stream_if. A stand-in DES core (known-answer
// vector plus a keyed mixing function) drives des_cipher_text so the block's
// sequencing, byte ordering and key retention can be checked end to end.
module tb_des_stream_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_is_key;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [63:0] des_plain_text;
    logic [63:0] des_cipher_key;
    logic [63:0] des_cipher_text;
    logic        key_loaded;
    logic        key_parity_err;

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B  = 64'h123457799BBCDFF1;
    localparam logic [63:0] TEXT_A = 64'h0123456789ABCDEF;
    localparam logic [63:0] CIPH_A = 64'h85E813540F0AB405;

`ifdef DES_KEY_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    int nchk  = 0;
    int nfail = 0;
    logic [63:0] model_key;

    always #5 clk = ~clk;

    // Stand-in combinational core
    function automatic logic [63:0] fake_des(input logic [63:0] k, input logic [63:0] p);
        if (k == KEY_A && p == TEXT_A)
            return CIPH_A;
        return {p[40:0], p[63:41]} ^ k ^ (k << 3) ^ 64'h0F1E2D3C4B5A6978;
    endfunction

    function automatic logic [7:0] byte_of(input logic [63:0] v, input int i);
        logic [63:0] t;
        t = v << (8 * i);
        return t[63:56];
    endfunction

    assign des_cipher_text = fake_des(des_cipher_key, des_plain_text);

    des_stream_if dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_is_key        (s_is_key),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .des_plain_text  (des_plain_text),
        .des_cipher_key  (des_cipher_key),
        .des_cipher_text (des_cipher_text),
        .key_loaded      (key_loaded),
        .key_parity_err  (key_parity_err)
    );

    // Offer one byte after 'gap' idle cycles; returns 1ns after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input logic k, input int gap);
        int guard = 0;
        repeat (gap) begin @(posedge clk); #1; end
        s_data = b; s_is_key = k; s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && guard < 50) begin @(negedge clk); guard++; end
        nchk++;
        if (s_ready !== 1'b1) begin
            nfail++;
            $display("FAIL send_timeout s_ready=%b required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_is_key = 1'($urandom); s_data = 8'($urandom);
    endtask

    // Send an optional key block then a text block; s_is_key is random after byte 0.
    task automatic send_block(input bit with_key, input logic [63:0] key,
                              input logic [63:0] text, input bit gaps);
        for (int i = 0; i < 8 && with_key; i++)
            send_byte(byte_of(key, i), (i == 0) ? 1'b1 : 1'($urandom),
                      gaps ? $urandom_range(0, 3) : 0);
        for (int i = 0; i < 8; i++)
            send_byte(byte_of(text, i), (i == 0 && !with_key) ? 1'b0 : 1'($urandom),
                      gaps ? $urandom_range(0, 3) : 0);
        if (with_key) model_key = key;
    endtask

    // Receive 8 bytes starting in the capture cycle; optional random stalls of 1-5 cycles.
    task automatic recv_block(input logic [63:0] exp, input bit stalls, input string name);
        int got = 0, guard = 0, it = 0, first_seen = -1, stall_left = 0;
        bit was_stalled = 0;
        logic [7:0] held;
        logic held_last;
        while (got < 8 && guard < 300) begin
            if (stalls && stall_left == 0 && $urandom_range(0, 2) == 0)
                stall_left = $urandom_range(1, 5);
            m_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            @(negedge clk);
            if (it == 0) begin
                nchk++;
                if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
                    nfail++;
                    $display("FAIL %s_capture s_ready=%b m_valid=%b required 0 0", name, s_ready, m_valid);
                end
            end
            if (m_valid === 1'b1) begin
                if (first_seen < 0) begin
                    first_seen = it;
                    nchk++;
                    if (first_seen != 1) begin
                        nfail++;
                        $display("FAIL %s_latency m_valid first at cycle %0d required 1", name, first_seen);
                    end
                end
                nchk++;
                if (s_ready !== 1'b0) begin
                    nfail++;
                    $display("FAIL %s_sready_send s_ready=%b required 0", name, s_ready);
                end
                if (was_stalled) begin
                    nchk++;
                    if (m_data !== held || m_last !== held_last) begin
                        nfail++;
                        $display("FAIL %s_stall_hold m_data=%h m_last=%b required %h %b",
                                 name, m_data, m_last, held, held_last);
                    end
                end
                if (m_ready) begin
                    nchk++;
                    if (m_data !== byte_of(exp, got) || m_last !== (got == 7)) begin
                        nfail++;
                        $display("FAIL %s_byte%0d m_data=%h m_last=%b required %h %b",
                                 name, got, m_data, m_last, byte_of(exp, got), (got == 7));
                    end
                    got++;
                    was_stalled = 0;
                end else begin
                    held = m_data; held_last = m_last; was_stalled = 1;
                end
            end
            @(posedge clk); #1;
            guard++; it++;
        end
        m_ready = 1'b1;
        nchk++;
        if (got != 8) begin
            nfail++;
            $display("FAIL %s_recv_timeout bytes=%0d required 8", name, got);
        end
        nchk++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            nfail++;
            $display("FAIL %s_back_idle m_valid=%b s_ready=%b required 0 1", name, m_valid, s_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        nchk++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00 ||
            des_plain_text !== 64'd0 || des_cipher_key !== 64'd0 ||
            key_loaded !== 1'b0 || key_parity_err !== 1'b0) begin
            nfail++;
            $display("FAIL reset_values rdy=%b mv=%b ml=%b md=%h pt=%h key=%h kl=%b pe=%b required 1 0 0 00 0 0 0 0",
                     s_ready, m_valid, m_last, m_data, des_plain_text, des_cipher_key,
                     key_loaded, key_parity_err);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        nchk++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || key_loaded !== 1'b0) begin
            nfail++;
            $display("FAIL reset_release s_ready=%b m_valid=%b key_loaded=%b required 1 0 0",
                     s_ready, m_valid, key_loaded);
        end
        model_key = 64'd0;
    endtask

    task automatic test_known_vector();
        send_block(1'b1, KEY_A, TEXT_A, 1'b0);
        nchk++;
        if (key_loaded !== 1'b1 || des_cipher_key !== KEY_A || des_plain_text !== TEXT_A) begin
            nfail++;
            $display("FAIL kv_regs key_loaded=%b key=%h pt=%h required 1 %h %h",
                     key_loaded, des_cipher_key, des_plain_text, KEY_A, TEXT_A);
        end
        recv_block(CIPH_A, 1'b0, "kv");
    endtask

    task automatic test_text_only();
        send_block(1'b0, 64'd0, TEXT_A, 1'b0);
        nchk++;
        if (des_cipher_key !== KEY_A) begin
            nfail++;
            $display("FAIL text_only_key key=%h required %h", des_cipher_key, KEY_A);
        end
        recv_block(CIPH_A, 1'b0, "text_only");
    endtask

    task automatic test_stalls();
        send_block(1'b1, KEY_A, TEXT_A, 1'b1);
        recv_block(CIPH_A, 1'b1, "stalls");
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++) begin
            bit          wk;
            logic [63:0] k, t;
            wk = 1'($urandom);
            k  = {$urandom, $urandom};
            t  = {$urandom, $urandom};
            send_block(wk, k, t, 1'b1);
            recv_block(fake_des(model_key, t), 1'b1, "random");
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++)
            send_byte(byte_of(TEXT_A, i), (i == 0) ? 1'b0 : 1'($urandom), 0);
        nchk++;
        if (key_loaded !== 1'b1) begin
            nfail++;
            $display("FAIL mid_key_loaded key_loaded=%b required 1", key_loaded);
        end
        test_reset();
        send_block(1'b0, 64'd0, TEXT_A, 1'b0);
        nchk++;
        if (des_cipher_key !== 64'd0 || des_plain_text !== TEXT_A) begin
            nfail++;
            $display("FAIL mid_zero_key key=%h pt=%h required 0 %h", des_cipher_key, des_plain_text, TEXT_A);
        end
        recv_block(fake_des(64'd0, TEXT_A), 1'b0, "zero_key");
    endtask

    task automatic parity_load(input logic [63:0] key, input string name);
        bit exp_err = 0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = (i < 8) ? byte_of(key, i) : byte_of(TEXT_A, i - 8);
            send_byte(b, (i == 0) ? 1'b1 : 1'($urandom), 0);
            if (i < 8) begin
                bit bad;
                bad = ($countones(b) % 2) == 0;
                exp_err = (i == 0) ? bad : (exp_err | bad);
            end
            nchk++;
            if (key_parity_err !== (exp_err && PAR_EN)) begin
                nfail++;
                $display("FAIL %s_flag_byte%0d key_parity_err=%b required %b",
                         name, i, key_parity_err, (exp_err && PAR_EN));
            end
        end
        model_key = key;
        recv_block(fake_des(key, TEXT_A), 1'b0, name);
    endtask

    task automatic test_parity();
        parity_load(KEY_B, "parity_bad");
        parity_load(KEY_A, "parity_good");
    endtask

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        s_is_key = 1'b0;
        m_ready  = 1'b1;
        model_key = 64'd0;
        #2;
        test_reset();
        test_known_vector();
        test_text_only();
        test_stalls();
        test_random();
        test_reset_mid();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
